// File: rtl/mem_arbiter_pkg.sv
// Shared types for the IF/MEM SRAM arbiter: word width, FSM states and grant owner.
package mem_arbiter_pkg;

  localparam int unsigned WORD_W = 16;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RD       = 3'd1,
    S_WR_SETUP = 3'd2,
    S_WR_PULSE = 3'd3,
    S_WR_HOLD  = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  typedef enum logic {
    OWNER_IF  = 1'b0,
    OWNER_MEM = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Pipeline-side request/ready handshakes plus SRAM pin bundle of the arbiter.
interface mem_arbiter_if;
  import mem_arbiter_pkg::*;

  logic  if_req;
  word_t if_addr;
  word_t if_rdata;
  logic  if_ready;

  logic  mem_req;
  logic  mem_we;
  word_t mem_addr;
  word_t mem_wdata;
  word_t mem_rdata;
  logic  mem_ready;
  logic  hold;

  word_t ram_addr;
  word_t ram_dout;
  logic  ram_dout_en;
  word_t ram_din;
  logic  ram_ce_n;
  logic  ram_oe_n;
  logic  ram_we_n;

  modport slave (
    input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, ram_din,
    output if_rdata, if_ready, mem_rdata, mem_ready, hold,
           ram_addr, ram_dout, ram_dout_en, ram_ce_n, ram_oe_n, ram_we_n
  );

  modport master (
    output if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, ram_din,
    input  if_rdata, if_ready, mem_rdata, mem_ready, hold,
           ram_addr, ram_dout, ram_dout_en, ram_ce_n, ram_oe_n, ram_we_n
  );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port SRAM controller shared by fetch and MEM stage; MEM wins arbitration,
// strobes are sequenced by a small FSM and all pin/ready outputs are registered.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned RD_CYCLES = 1,
  parameter int unsigned WR_CYCLES = 1
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);

  localparam int unsigned MAX_CYC = (RD_CYCLES > WR_CYCLES) ? RD_CYCLES : WR_CYCLES;
  localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_CYCLES - 1);
  localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WR_CYCLES - 1);

  state_t           state, state_nxt;
  owner_t           owner, owner_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  word_t            addr_nxt, dout_nxt;
  logic             ce_n_nxt, oe_n_nxt, we_n_nxt, dout_en_nxt;
  logic             if_ready_nxt, mem_ready_nxt, capture;

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      owner           <= OWNER_IF;
      cnt             <= '0;
      bus.ram_addr    <= '0;
      bus.ram_dout    <= '0;
      bus.ram_dout_en <= 1'b0;
      bus.ram_ce_n    <= 1'b1;
      bus.ram_oe_n    <= 1'b1;
      bus.ram_we_n    <= 1'b1;
      bus.if_ready    <= 1'b0;
      bus.mem_ready   <= 1'b0;
      bus.if_rdata    <= '0;
      bus.mem_rdata   <= '0;
    end else begin
      state           <= state_nxt;
      owner           <= owner_nxt;
      cnt             <= cnt_nxt;
      bus.ram_addr    <= addr_nxt;
      bus.ram_dout    <= dout_nxt;
      bus.ram_dout_en <= dout_en_nxt;
      bus.ram_ce_n    <= ce_n_nxt;
      bus.ram_oe_n    <= oe_n_nxt;
      bus.ram_we_n    <= we_n_nxt;
      bus.if_ready    <= if_ready_nxt;
      bus.mem_ready   <= mem_ready_nxt;
      if (capture && owner == OWNER_IF)  bus.if_rdata  <= bus.ram_din;
      if (capture && owner == OWNER_MEM) bus.mem_rdata <= bus.ram_din;
    end
  end

  // Pin levels are decoded for the state being entered, so the registered
  // strobes line up with the state they belong to.
  always_comb begin
    state_nxt     = state;
    owner_nxt     = owner;
    cnt_nxt       = cnt;
    addr_nxt      = bus.ram_addr;
    dout_nxt      = bus.ram_dout;
    ce_n_nxt      = 1'b1;
    oe_n_nxt      = 1'b1;
    we_n_nxt      = 1'b1;
    dout_en_nxt   = 1'b0;
    if_ready_nxt  = 1'b0;
    mem_ready_nxt = 1'b0;
    capture       = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (bus.mem_req) begin
          owner_nxt = OWNER_MEM;
          addr_nxt  = bus.mem_addr;
          dout_nxt  = bus.mem_wdata;
          cnt_nxt   = '0;
          ce_n_nxt  = 1'b0;
          if (bus.mem_we) begin
            state_nxt   = S_WR_SETUP;
            dout_en_nxt = 1'b1;
          end else begin
            state_nxt = S_RD;
            oe_n_nxt  = 1'b0;
          end
        end else if (bus.if_req) begin
          owner_nxt = OWNER_IF;
          addr_nxt  = bus.if_addr;
          cnt_nxt   = '0;
          state_nxt = S_RD;
          ce_n_nxt  = 1'b0;
          oe_n_nxt  = 1'b0;
        end
      end
      S_RD: begin
        if (cnt == RD_LAST) begin
          state_nxt = S_DONE;
          capture   = 1'b1;
          if (owner == OWNER_MEM) mem_ready_nxt = 1'b1;
          else                    if_ready_nxt  = 1'b1;
        end else begin
          cnt_nxt  = cnt + CNT_W'(1);
          ce_n_nxt = 1'b0;
          oe_n_nxt = 1'b0;
        end
      end
      S_WR_SETUP: begin
        state_nxt   = S_WR_PULSE;
        cnt_nxt     = '0;
        ce_n_nxt    = 1'b0;
        we_n_nxt    = 1'b0;
        dout_en_nxt = 1'b1;
      end
      S_WR_PULSE: begin
        ce_n_nxt    = 1'b0;
        dout_en_nxt = 1'b1;
        if (cnt == WR_LAST) begin
          state_nxt = S_WR_HOLD;
        end else begin
          cnt_nxt  = cnt + CNT_W'(1);
          we_n_nxt = 1'b0;
        end
      end
      S_WR_HOLD: begin
        state_nxt     = S_DONE;
        mem_ready_nxt = 1'b1;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign bus.hold = bus.mem_req & ~bus.mem_ready;

endmodule
